shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle right-shift unit that sits directly in front of the ALU's single-bit SHIFT_RIGHT stage. It accepts an 8-bit operand and a 0–7 shift amount over a valid/ready handshake. It applies one right shift per clock, either logical or arithmetic, and returns the result with the last bit shifted out over a second valid/ready handshake. This lets the ALU support variable-distance shifts while reusing the one-position shifter datapath.

## Interface
- WIDTH, 8, operand/result width
- AMT_W, 3, shift-amount width; max shift = 2^AMT_W − 1
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream request valid
- in_ready  output  1  sequencer can accept a request
- in_op  input  WIDTH  operand to shift
- in_amt  input  AMT_W  number of one-bit right shifts
- in_arith  input  1  1 = arithmetic (MSB replicated), 0 = logical (0 shifted in)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  shifted operand
- out_carry  output  1  last bit shifted out of bit 0; 0 if in_amt = 0
- busy  output  1  high in SHIFT and DONE states

## Operation
- States:
  - IDLE, SHIFT and DONE. Encoding is free.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load data_reg = in_op, cnt = in_amt, arith_reg = in_arith and carry_reg = 0.
  - Next state is SHIFT if in_amt ≠ 0, otherwise DONE.
- SHIFT, every cycle:
  - carry_reg ← data_reg[0].
  - data_reg ← {fill, data_reg[WIDTH−1:1]}, where fill = arith_reg ? data_reg[WIDTH−1] : 0.
  - cnt ← cnt − 1.
  - When cnt = 1 (the last shift), next state is DONE.
- DONE:
  - out_valid = 1, out_result = data_reg, out_carry = carry_reg.
  - On out_ready, next state is IDLE.
  - Outputs hold stable while out_ready = 0 (no bounded wait).
- in_ready = (state == IDLE) && rst_n.
  - No new request is accepted in DONE, even if out_ready is high that cycle.
  - Peak throughput is one operation per in_amt + 2 cycles.
- Inputs are sampled only at the acceptance edge.
  - Changes to in_op, in_amt or in_arith after acceptance have no effect on the in-flight operation.
- in_valid while not ready: the request is ignored. Upstream must hold it until accepted.
- out_result and out_carry are registered. They equal data_reg and carry_reg in all states and are meaningful only while out_valid = 1.

## Timing
- Reset is sampled at a clk edge with rst_n = 0:
  - state = IDLE.
  - data_reg = 0, carry_reg = 0, cnt = 0, arith_reg = 0.
  - Therefore out_valid = 0, out_result = 0, out_carry = 0, busy = 0.
  - in_ready = 0 while rst_n = 0, and 1 from the first cycle after release.
- Reset mid-operation (SHIFT or DONE) aborts the operation. No out_valid pulse is produced and the result is discarded.
- Latency:
  - Request accepted at edge E0 → out_valid high in the cycle after edge E0 + in_amt.
  - in_amt = 0: out_valid is high the cycle after E0.
  - in_amt = 7: out_valid is high 7 cycles after E0.
- Result handshake completes at the edge where out_valid && out_ready. in_ready rises in the following cycle.
- Simultaneous in_valid and out_ready in DONE: the result is consumed and the request waits until the next cycle in IDLE.
- Arithmetic shift of a negative operand saturates toward all-ones. Logical shift saturates toward zero. There is no wrap-around because in_amt < WIDTH.

## Test plan
- in_op = 8'd15, in_amt = 1, logical → out_result = 8'b00000111, out_carry = 1, out_valid one cycle after acceptance.
- in_op = 8'b00000001, in_amt = 1, logical → out_result = 8'h00, out_carry = 1. Then in_op = 8'hFF, in_amt = 7, logical → out_result = 8'h01, out_carry = 1, out_valid 7 cycles after acceptance.
- in_op = 8'h80, in_amt = 3, arithmetic → out_result = 8'hF0, out_carry = 0. The same operand with logical → 8'h10, out_carry = 0.
- in_op = 8'hA5, in_amt = 0 → out_result = 8'hA5, out_carry = 0, out_valid the cycle after acceptance, in_ready low in that cycle.
- Backpressure: in_op = 8'h3C, in_amt = 2, with out_ready held 0 for 5 cycles → out_valid, out_result = 8'h0F and out_carry = 0 stay stable. in_ready stays 0 even with in_valid high. in_ready returns to 1 the cycle after out_ready rises.
- Reset mid-shift: in_op = 8'hFF, in_amt = 6, rst_n low for one edge after 2 shifts → out_valid never asserts, outputs = 0, busy = 0. The next request (8'h04, amt 2 → 8'h01, carry 0) completes normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the multi-cycle right-shift sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op;
    logic [AMT_W-1:0] in_amt;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;

    modport master (
        output in_valid, in_op, in_amt, in_arith, out_ready,
        input  in_ready, out_valid, out_result, out_carry
    );

    modport slave (
        input  in_valid, in_op, in_amt, in_arith, out_ready,
        output in_ready, out_valid, out_result, out_carry
    );
endinterface

// File: rtl/shift_sequencer.sv
// Variable-distance right shift built from a one-position shifter, one shift per clock.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_reg;
    logic [AMT_W-1:0] cnt;
    logic             arith_reg;
    logic             carry_reg;
    logic             accept;
    logic             fill;

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = rst_n;
                accept       = bus.in_valid && rst_n;
                if (accept)
                    state_nxt = (bus.in_amt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == AMT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arithmetic mode replicates the sign bit; logical mode shifts in zero.
    assign fill = arith_reg & data_reg[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_reg  <= '0;
            cnt       <= '0;
            arith_reg <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_reg  <= bus.in_op;
                cnt       <= bus.in_amt;
                arith_reg <= bus.in_arith;
                carry_reg <= 1'b0;
            end else if (state == SHIFT) begin
                carry_reg <= data_reg[0];
                data_reg  <= {fill, data_reg[WIDTH-1:1]};
                cnt       <= cnt - AMT_W'(1);
            end
        end
    end

    assign bus.out_result = data_reg;
    assign bus.out_carry  = carry_reg;
endmodule
